// File: rtl/dispatch_rr_pkg.sv
// Shared types and helpers for the round-robin request dispatcher.
package dispatch_rr_pkg;

    localparam int unsigned LANE_MAX   = 16;
    localparam int unsigned LANE_W_MAX = 4;
    localparam logic [15:0] STALL_MAX  = 16'hFFFF;

    // Wide enough for the largest supported lane count; instances slice it down.
    typedef logic [LANE_W_MAX-1:0] lane_index_t;

    function automatic logic [LANE_MAX-1:0] onehot(input lane_index_t idx, input logic en);
        onehot = en ? (LANE_MAX'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/dispatch_rr_pick.sv
// Finds the first ready lane at or after a start index, wrapping at N.
module dispatch_rr_pick
    import dispatch_rr_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned LW = 2
)(
    input  logic [LW-1:0] i_start,
    input  logic [N-1:0]  i_rdy,
    output logic [LW-1:0] o_tgt,
    output logic          o_found
);

    always_comb begin : p_pick
        int unsigned w_lane;
        o_tgt   = i_start;
        o_found = 1'b0;
        w_lane  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            // start < N, so a single subtraction is enough to wrap
            w_lane = 32'(i_start) + k;
            if (w_lane >= N) begin
                w_lane = w_lane - N;
            end
            if (!o_found && i_rdy[w_lane]) begin
                o_found = 1'b1;
                o_tgt   = LW'(w_lane);
            end
        end
    end

endmodule

// File: rtl/dispatch_rr.sv
// Deals one request stream round-robin across funnelWidth lanes through a
// one-entry holding register, with a saturating debug stall counter.
module dispatch_rr
    import dispatch_rr_pkg::*;
#(
    parameter int unsigned funnelWidth = 4,
    parameter int unsigned dataWidth   = 32,
    parameter bit          strictOrder = 1'b1
)(
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           in_enq_ena,
    input  logic [dataWidth-1:0]           in_enq_v,
    output logic                           in_enq_rdy,
    output logic [funnelWidth-1:0]         out_enq_ena,
    output logic [dataWidth-1:0]           out_enq_v,
    input  logic [funnelWidth-1:0]         out_enq_rdy,
    output logic [$clog2(funnelWidth)-1:0] lane,
    output logic                           busy,
    output logic [15:0]                    stallCount
);

    localparam int unsigned LW = $clog2(funnelWidth);

    logic                 r_hold_valid;
    logic [dataWidth-1:0] r_hold_data;
    logic [LW-1:0]        r_index;
    logic [15:0]          r_stall;

    logic [LW-1:0] w_tgt;
    logic          w_found;
    logic          w_fire;
    logic          w_accept;

    // Strict mode always targets the current index; skip mode searches for a ready lane.
    generate
        if (strictOrder) begin : g_strict
            assign w_tgt   = r_index;
            assign w_found = 1'b1;
        end else begin : g_skip
            dispatch_rr_pick #(
                .N  (funnelWidth),
                .LW (LW)
            ) u_pick (
                .i_start (r_index),
                .i_rdy   (out_enq_rdy),
                .o_tgt   (w_tgt),
                .o_found (w_found)
            );
        end
    endgenerate

    assign w_fire   = r_hold_valid && w_found && out_enq_rdy[w_tgt];
    assign w_accept = in_enq_ena && in_enq_rdy;

    assign out_enq_ena = funnelWidth'(onehot(LANE_W_MAX'(w_tgt), w_fire));
    assign out_enq_v   = r_hold_data;
    assign in_enq_rdy  = !r_hold_valid || w_fire;
    assign lane        = r_index;
    assign busy        = r_hold_valid;
    assign stallCount  = r_stall;

    // Holding register, lane pointer and stall counter; an ENA without RDY is ignored.
    always_ff @(posedge CLK or negedge nRST) begin : p_state
        if (!nRST) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_index      <= '0;
            r_stall      <= '0;
        end else begin
            if (w_accept) begin
                r_hold_data  <= in_enq_v;
                r_hold_valid <= 1'b1;
            end else if (w_fire) begin
                r_hold_valid <= 1'b0;
            end
            if (w_fire) begin
                r_index <= (32'(w_tgt) == funnelWidth - 1) ? '0 : w_tgt + LW'(1);
            end
            if (r_hold_valid && !w_fire && (r_stall != STALL_MAX)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_rr.sv
// Bench for dispatch_rr: strict N=4, skip N=4 and strict N=3 instances
// checked every cycle against a queue-level model plus directed literals.
module tb_dispatch_rr;

    localparam int NI = 3;
    localparam int NN  [NI] = '{4, 4, 3};
    localparam int STR [NI] = '{1, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena   [NI];
    logic [31:0] din   [NI];
    logic [3:0]  ordy  [NI];

    logic        rdy_o   [NI];
    logic [3:0]  ena_o   [NI];
    logic [31:0] dout    [NI];
    logic [1:0]  lane_o  [NI];
    logic        busy_o  [NI];
    logic [15:0] stall_o [NI];
    logic [2:0]  ena_n3;

    // model state
    bit          m_full  [NI];
    logic [31:0] m_data  [NI];
    int          m_idx   [NI];
    int          m_stall [NI];

    // fire log taken from DUT outputs
    int          q_inst [$];
    int          q_lane [$];
    logic [31:0] q_data [$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dispatch_rr #(.funnelWidth(4), .dataWidth(32), .strictOrder(1'b1)) u_strict (
        .CLK(clk), .nRST(rst_n),
        .in_enq_ena(ena[0]), .in_enq_v(din[0]), .in_enq_rdy(rdy_o[0]),
        .out_enq_ena(ena_o[0]), .out_enq_v(dout[0]), .out_enq_rdy(ordy[0]),
        .lane(lane_o[0]), .busy(busy_o[0]), .stallCount(stall_o[0])
    );

    dispatch_rr #(.funnelWidth(4), .dataWidth(32), .strictOrder(1'b0)) u_skip (
        .CLK(clk), .nRST(rst_n),
        .in_enq_ena(ena[1]), .in_enq_v(din[1]), .in_enq_rdy(rdy_o[1]),
        .out_enq_ena(ena_o[1]), .out_enq_v(dout[1]), .out_enq_rdy(ordy[1]),
        .lane(lane_o[1]), .busy(busy_o[1]), .stallCount(stall_o[1])
    );

    dispatch_rr #(.funnelWidth(3), .dataWidth(32), .strictOrder(1'b1)) u_n3 (
        .CLK(clk), .nRST(rst_n),
        .in_enq_ena(ena[2]), .in_enq_v(din[2]), .in_enq_rdy(rdy_o[2]),
        .out_enq_ena(ena_n3), .out_enq_v(dout[2]), .out_enq_rdy(ordy[2][2:0]),
        .lane(lane_o[2]), .busy(busy_o[2]), .stallCount(stall_o[2])
    );
    assign ena_o[2] = {1'b0, ena_n3};

    // Target lane from the rules: strict = pointer, skip = first ready lane from pointer.
    function automatic int tgt_of(input int i);
        tgt_of = m_idx[i];
        if (STR[i] == 0) begin
            for (int k = NN[i] - 1; k >= 0; k--) begin
                if (ordy[i][(m_idx[i] + k) % NN[i]]) tgt_of = (m_idx[i] + k) % NN[i];
            end
        end
    endfunction

    function automatic bit fire_of(input int i);
        fire_of = m_full[i] && ordy[i][tgt_of(i)];
    endfunction

    always @(posedge clk or negedge rst_n) begin : p_model
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_full[i]  <= 1'b0;
                m_data[i]  <= '0;
                m_idx[i]   <= 0;
                m_stall[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (fire_of(i)) m_idx[i] <= (tgt_of(i) + 1) % NN[i];
                if (ena[i] && (!m_full[i] || fire_of(i))) begin
                    m_data[i] <= din[i];
                    m_full[i] <= 1'b1;
                end else if (fire_of(i)) begin
                    m_full[i] <= 1'b0;
                end
                if (m_full[i] && !fire_of(i))
                    m_stall[i] <= (m_stall[i] >= 65535) ? 65535 : m_stall[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            logic [3:0] exp_ena;
            exp_ena = fire_of(i) ? 4'(1 << tgt_of(i)) : 4'b0;
            chk("out_ena", i, 32'(ena_o[i]), 32'(exp_ena));
            chk("in_rdy", i, 32'(rdy_o[i]), 32'(!m_full[i] || fire_of(i)));
            chk("lane", i, 32'(lane_o[i]), 32'(m_idx[i]));
            chk("busy", i, 32'(busy_o[i]), 32'(m_full[i]));
            chk("stall", i, 32'(stall_o[i]), 32'(m_stall[i]));
            if (m_full[i]) chk("out_v", i, dout[i], m_data[i]);
            if (ena[i]) chk("enq_while_not_rdy", i, 32'(rdy_o[i]), 32'd1);
            for (int b = 0; b < 4; b++) begin
                if (ena_o[i][b]) begin
                    q_inst.push_back(i);
                    q_lane.push_back(b);
                    q_data.push_back(dout[i]);
                end
            end
        end
    endtask

    // Compare at the falling edge, then return just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic log_clear();
        q_inst.delete();
        q_lane.delete();
        q_data.delete();
    endtask

    task automatic chk_log(input string nm, input int inst, input int el[$], input logic [31:0] ed[$]);
        int j;
        j = 0;
        for (int e = 0; e < q_inst.size(); e++) begin
            if (q_inst[e] == inst) begin
                if (j < el.size()) begin
                    chk({nm, "_lane"}, inst, 32'(q_lane[e]), 32'(el[j]));
                    chk({nm, "_data"}, inst, q_data[e], ed[j]);
                end
                j++;
            end
        end
        chk({nm, "_count"}, inst, 32'(j), 32'(el.size()));
    endtask

    initial begin : p_stim
        int          el [$];
        logic [31:0] ed [$];
        int          n55;

        for (int i = 0; i < NI; i++) begin
            ena[i]  = 1'b0;
            din[i]  = '0;
            ordy[i] = 4'hF;
        end
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
            chk("rst_lane", i, 32'(lane_o[i]), 32'd0);
            chk("rst_stall", i, 32'(stall_o[i]), 32'd0);
            chk("rst_rdy", i, 32'(rdy_o[i]), 32'd1);
        end

        // strict, all lanes ready, back-to-back
        log_clear();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) chk("t1_rdy", 0, 32'(rdy_o[0]), 32'd1);
            ena[0] = 1'b1;
            din[0] = 32'h10 + 32'(k);
            cyc();
        end
        ena[0] = 1'b0;
        cyc();
        cyc();
        el.delete(); ed.delete();
        for (int k = 0; k < 8; k++) begin
            el.push_back(k % 4);
            ed.push_back(32'h10 + 32'(k));
        end
        chk_log("t1", 0, el, ed);
        chk("t1_stall", 0, 32'(stall_o[0]), 32'd0);

        // strict, lane 2 blocked while 0xA2 is held
        log_clear();
        ordy[0] = 4'b1011;
        ena[0] = 1'b1; din[0] = 32'hA0; cyc();
        din[0] = 32'hA1; cyc();
        din[0] = 32'hA2; cyc();
        ena[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_busy", 0, 32'(busy_o[0]), 32'd1);
            chk("t2_rdy", 0, 32'(rdy_o[0]), 32'd0);
            cyc();
        end
        chk("t2_stall", 0, 32'(stall_o[0]), 32'd5);
        ordy[0] = 4'hF;
        #1;
        chk("t2_rdy_back", 0, 32'(rdy_o[0]), 32'd1);
        ena[0] = 1'b1; din[0] = 32'hA3; cyc();
        ena[0] = 1'b0;
        cyc();
        cyc();
        el.delete(); ed.delete();
        el.push_back(0); el.push_back(1); el.push_back(2); el.push_back(3);
        ed.push_back(32'hA0); ed.push_back(32'hA1); ed.push_back(32'hA2); ed.push_back(32'hA3);
        chk_log("t2", 0, el, ed);
        chk("t2_stall_after", 0, 32'(stall_o[0]), 32'd5);

        // skip mode with lanes 1 and 3 ready
        log_clear();
        ordy[1] = 4'b1010;
        ena[1] = 1'b1; din[1] = 32'h1; cyc();
        din[1] = 32'h2; cyc();
        chk("t3_lane_a", 1, 32'(lane_o[1]), 32'd2);
        din[1] = 32'h3; cyc();
        chk("t3_lane_b", 1, 32'(lane_o[1]), 32'd0);
        ena[1] = 1'b0; cyc();
        chk("t3_lane_c", 1, 32'(lane_o[1]), 32'd2);
        cyc();
        el.delete(); ed.delete();
        el.push_back(1); el.push_back(3); el.push_back(1);
        ed.push_back(32'h1); ed.push_back(32'h2); ed.push_back(32'h3);
        chk_log("t3", 1, el, ed);

        // N=3 wrap
        log_clear();
        for (int k = 0; k < 7; k++) begin
            ena[2] = 1'b1;
            din[2] = 32'h20 + 32'(k);
            cyc();
            chk("t4_lane_lt3", 2, 32'(lane_o[2] != 2'd3), 32'd1);
        end
        ena[2] = 1'b0;
        cyc();
        cyc();
        el.delete(); ed.delete();
        el.push_back(0); el.push_back(1); el.push_back(2); el.push_back(0);
        el.push_back(1); el.push_back(2); el.push_back(0);
        for (int k = 0; k < 7; k++) ed.push_back(32'h20 + 32'(k));
        chk_log("t4", 2, el, ed);

        // reset while a word is held
        log_clear();
        ordy[0] = 4'hF;
        ena[0] = 1'b1; din[0] = 32'h54; cyc();
        ena[0] = 1'b0; cyc();
        ordy[0] = 4'h0;
        ena[0] = 1'b1; din[0] = 32'h55; cyc();
        ena[0] = 1'b0;
        cyc();
        cyc();
        chk("t5_pre_lane", 0, 32'(lane_o[0]), 32'd1);
        chk("t5_pre_busy", 0, 32'(busy_o[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("t5_stall", 0, 32'(stall_o[0]), 32'd0);
        chk("t5_lane", 0, 32'(lane_o[0]), 32'd0);
        chk("t5_rdy", 0, 32'(rdy_o[0]), 32'd1);
        chk("t5_ena", 0, 32'(ena_o[0]), 32'd0);
        cyc();
        rst_n = 1'b1;
        ordy[0] = 4'hF;
        repeat (3) cyc();
        n55 = 0;
        for (int e = 0; e < q_data.size(); e++) if (q_data[e] == 32'h55) n55++;
        chk("t5_no_55", 0, 32'(n55), 32'd0);
        chk("t5_post_busy", 0, 32'(busy_o[0]), 32'd0);

        // stall counter saturation
        log_clear();
        ordy[0] = 4'h0;
        ena[0] = 1'b1; din[0] = 32'h77; cyc();
        ena[0] = 1'b0;
        repeat (70000) cyc();
        chk("t6_sat", 0, 32'(stall_o[0]), 32'h0000FFFF);
        chk("t6_busy", 0, 32'(busy_o[0]), 32'd1);
        ordy[0] = 4'hF;
        cyc();
        cyc();
        el.delete(); ed.delete();
        el.push_back(0);
        ed.push_back(32'h77);
        chk_log("t6", 0, el, ed);
        chk("t6_sat_after", 0, 32'(stall_o[0]), 32'h0000FFFF);
        chk("t6_busy_after", 0, 32'(busy_o[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
